// File: rtl/nes_pixel_fifo_if.sv
// Pixel FIFO bus: push side, pop side, control strobes and status.
// The master drives requests; the slave (the FIFO) returns data and status.
interface nes_pixel_fifo_if #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 512,
  parameter int LINE_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_eol;
  logic              rd_en;
  logic              flush;
  logic              clear_err;
  logic [DATA_W-1:0] rd_data;
  logic              rd_eol;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [AW:0]       level;
  logic [LINE_W-1:0] line_count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, wr_eol, rd_en, flush, clear_err,
    input  rd_data, rd_eol, rd_valid, full, empty, almost_full, almost_empty,
           level, line_count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, wr_eol, rd_en, flush, clear_err,
    output rd_data, rd_eol, rd_valid, full, empty, almost_full, almost_empty,
           level, line_count, overflow, underflow
  );
endinterface

// File: rtl/nes_pixel_fifo.sv
// Single-clock pixel FIFO with scanline (eol) accounting, registered read
// port, threshold flags and sticky overflow/underflow reporting.
module nes_pixel_fifo #(
  parameter int DATA_W    = 6,
  parameter int DEPTH     = 512,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4,
  parameter int LINE_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  nes_pixel_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       LV_ONE  = (AW+1)'(1);
  localparam logic [AW:0]       DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]       AF_TH   = (AW+1)'(AFULL_TH);
  localparam logic [AW:0]       AE_TH   = (AW+1)'(AEMPTY_TH);
  localparam logic [LINE_W-1:0] LC_ONE  = LINE_W'(1);
  localparam logic [LINE_W-1:0] LC_MAX  = '1;

  typedef struct packed {
    logic              eol;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t mem [DEPTH];

  logic [AW:0]       wr_ptr, rd_ptr, level, lvl_nxt;
  logic [LINE_W-1:0] line_cnt, lc_nxt;
  logic              ptr_full, ptr_empty;
  logic              pop_acc, push_acc, ovf_set, unf_set;
  logic              lc_inc, lc_dec;
  entry_t            rd_ent;

  assign ptr_empty = (wr_ptr == rd_ptr);
  assign ptr_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ent    = mem[rd_ptr[AW-1:0]];

  // A flush cycle swallows both requests, so neither can raise an error flag.
  assign pop_acc  = bus.rd_en && !ptr_empty && !bus.flush;
  assign push_acc = bus.wr_en && (!ptr_full || pop_acc) && !bus.flush;
  assign ovf_set  = bus.wr_en && ptr_full && !pop_acc && !bus.flush;
  assign unf_set  = bus.rd_en && ptr_empty && !bus.flush;
  assign lc_inc   = push_acc && bus.wr_eol;
  assign lc_dec   = pop_acc && rd_ent.eol;

  always_comb begin
    lvl_nxt = level;
    if (push_acc && !pop_acc)      lvl_nxt = level + LV_ONE;
    else if (pop_acc && !push_acc) lvl_nxt = level - LV_ONE;
    if (bus.flush)                 lvl_nxt = '0;
  end

  always_comb begin
    lc_nxt = line_cnt;
    if (lc_inc && !lc_dec && line_cnt != LC_MAX) lc_nxt = line_cnt + LC_ONE;
    else if (lc_dec && !lc_inc && line_cnt != '0) lc_nxt = line_cnt - LC_ONE;
    if (bus.flush)                                lc_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr[AW-1:0]] <= {bus.wr_eol, bus.wr_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      level            <= '0;
      line_cnt         <= '0;
      bus.full         <= 1'b0;
      bus.empty        <= 1'b1;
      bus.almost_full  <= 1'b0;
      bus.almost_empty <= 1'b1;
      bus.rd_valid     <= 1'b0;
      bus.rd_data      <= '0;
      bus.rd_eol       <= 1'b0;
      bus.overflow     <= 1'b0;
      bus.underflow    <= 1'b0;
    end else begin
      if (bus.flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push_acc) wr_ptr <= wr_ptr + LV_ONE;
        if (pop_acc)  rd_ptr <= rd_ptr + LV_ONE;
      end
      level            <= lvl_nxt;
      line_cnt         <= lc_nxt;
      bus.full         <= (lvl_nxt == DEPTH_L);
      bus.empty        <= (lvl_nxt == '0);
      bus.almost_full  <= (lvl_nxt >= AF_TH);
      bus.almost_empty <= (lvl_nxt <= AE_TH);
      bus.rd_valid     <= pop_acc;
      if (pop_acc) begin
        bus.rd_data <= rd_ent.data;
        bus.rd_eol  <= rd_ent.eol;
      end
      // Setting beats clearing when both land in the same cycle.
      bus.overflow  <= ovf_set | (bus.overflow  & ~bus.clear_err);
      bus.underflow <= unf_set | (bus.underflow & ~bus.clear_err);
    end
  end

  assign bus.level      = level;
  assign bus.line_count = line_cnt;
endmodule

// File: tb/tb_nes_pixel_fifo.sv
// Directed bench for nes_pixel_fifo using a 16-entry instance with a 3-bit
// line counter so that full, wrap and saturation are reached quickly.
module tb_nes_pixel_fifo;
  localparam int DW = 6;
  localparam int DP = 16;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  nes_pixel_fifo_if #(.DATA_W(DW), .DEPTH(DP), .LINE_W(LW)) bus ();

  nes_pixel_fifo #(
    .DATA_W(DW), .DEPTH(DP), .AFULL_TH(DP-4), .AEMPTY_TH(4), .LINE_W(LW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic step(input logic we, input logic [DW-1:0] wd, input logic weol,
                      input logic re, input logic fl, input logic ce);
    bus.wr_en = we; bus.wr_data = wd; bus.wr_eol = weol;
    bus.rd_en = re; bus.flush = fl; bus.clear_err = ce;
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.wr_eol = 1'b0; bus.rd_en = 1'b0;
    bus.flush = 1'b0; bus.clear_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty got %b want 1", bus.empty); end
    vectors++; if (bus.almost_empty !== 1'b1) begin miscompares++; $display("FAIL rst_aempty got %b want 1", bus.almost_empty); end
    vectors++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin miscompares++; $display("FAIL rst_full got %b/%b want 0/0", bus.full, bus.almost_full); end
    vectors++; if (bus.level !== 5'd0 || bus.line_count !== 3'd0) begin miscompares++; $display("FAIL rst_level got %0d/%0d want 0/0", bus.level, bus.line_count); end
    vectors++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 6'h00 || bus.rd_eol !== 1'b0) begin miscompares++; $display("FAIL rst_rd got %b/%h/%b want 0/00/0", bus.rd_valid, bus.rd_data, bus.rd_eol); end
    vectors++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b/%b want 0/0", bus.overflow, bus.underflow); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    step(1, 6'h27, 0, 0, 0, 0);
    vectors++; if (bus.empty !== 1'b0 || bus.level !== 5'd1) begin miscompares++; $display("FAIL basic_push1 got empty=%b lvl=%0d want 0/1", bus.empty, bus.level); end
    step(1, 6'h0F, 0, 0, 0, 0);
    step(1, 6'h30, 1, 0, 0, 0);
    vectors++; if (bus.level !== 5'd3 || bus.line_count !== 3'd1) begin miscompares++; $display("FAIL basic_fill got lvl=%0d lc=%0d want 3/1", bus.level, bus.line_count); end
    step(0, 6'h00, 0, 1, 0, 0);
    vectors++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 6'h27 || bus.rd_eol !== 1'b0) begin miscompares++; $display("FAIL basic_pop1 got %b/%h/%b want 1/27/0", bus.rd_valid, bus.rd_data, bus.rd_eol); end
    step(0, 6'h00, 0, 1, 0, 0);
    vectors++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 6'h0F || bus.rd_eol !== 1'b0) begin miscompares++; $display("FAIL basic_pop2 got %b/%h/%b want 1/0f/0", bus.rd_valid, bus.rd_data, bus.rd_eol); end
    step(0, 6'h00, 0, 1, 0, 0);
    vectors++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 6'h30 || bus.rd_eol !== 1'b1) begin miscompares++; $display("FAIL basic_pop3 got %b/%h/%b want 1/30/1", bus.rd_valid, bus.rd_data, bus.rd_eol); end
    vectors++; if (bus.line_count !== 3'd0 || bus.empty !== 1'b1) begin miscompares++; $display("FAIL basic_lc got lc=%0d empty=%b want 0/1", bus.line_count, bus.empty); end
    step(0, 6'h00, 0, 0, 0, 0);
    vectors++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 6'h30) begin miscompares++; $display("FAIL basic_hold got %b/%h want 0/30", bus.rd_valid, bus.rd_data); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DP; i++) step(1, 6'(i), 0, 0, 0, 0);
    vectors++; if (bus.full !== 1'b1 || bus.level !== 5'd16 || bus.almost_full !== 1'b1) begin miscompares++; $display("FAIL full_fill got full=%b lvl=%0d af=%b want 1/16/1", bus.full, bus.level, bus.almost_full); end
    step(1, 6'h3F, 0, 0, 0, 0);
    vectors++; if (bus.overflow !== 1'b1 || bus.level !== 5'd16) begin miscompares++; $display("FAIL full_ovf got ovf=%b lvl=%0d want 1/16", bus.overflow, bus.level); end
    step(0, 6'h00, 0, 0, 0, 1);
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL full_clr got %b want 0", bus.overflow); end
    step(1, 6'h3F, 0, 1, 0, 0);
    vectors++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 6'h00) begin miscompares++; $display("FAIL full_pp_rd got %b/%h want 1/00", bus.rd_valid, bus.rd_data); end
    vectors++; if (bus.level !== 5'd16 || bus.overflow !== 1'b0 || bus.full !== 1'b1) begin miscompares++; $display("FAIL full_pp_lvl got lvl=%0d ovf=%b full=%b want 16/0/1", bus.level, bus.overflow, bus.full); end
    for (int i = 1; i <= DP; i++) begin
      logic [DW-1:0] exp_d;
      exp_d = (i == DP) ? 6'h3F : 6'(i);
      step(0, 6'h00, 0, 1, 0, 0);
      vectors++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_d) begin miscompares++; $display("FAIL full_drain%0d got %b/%h want 1/%h", i, bus.rd_valid, bus.rd_data, exp_d); end
    end
    vectors++; if (bus.empty !== 1'b1 || bus.almost_empty !== 1'b1 || bus.full !== 1'b0) begin miscompares++; $display("FAIL full_empty got e=%b ae=%b f=%b want 1/1/0", bus.empty, bus.almost_empty, bus.full); end
  endtask

  task automatic test_empty_pushpop();
    step(1, 6'h2A, 0, 1, 0, 0);
    vectors++; if (bus.underflow !== 1'b1 || bus.rd_valid !== 1'b0 || bus.level !== 5'd1) begin miscompares++; $display("FAIL epp got unf=%b vld=%b lvl=%0d want 1/0/1", bus.underflow, bus.rd_valid, bus.level); end
    step(0, 6'h00, 0, 1, 0, 1);
    vectors++; if (bus.underflow !== 1'b0 || bus.rd_valid !== 1'b1 || bus.rd_data !== 6'h2A) begin miscompares++; $display("FAIL epp_pop got unf=%b vld=%b d=%h want 0/1/2a", bus.underflow, bus.rd_valid, bus.rd_data); end
    step(0, 6'h00, 0, 1, 0, 1);
    vectors++; if (bus.underflow !== 1'b1) begin miscompares++; $display("FAIL set_over_clr got %b want 1", bus.underflow); end
  endtask

  task automatic test_line_flush();
    for (int i = 0; i < 9; i++) step(1, 6'(i + 8), 1, 0, 0, 0);
    vectors++; if (bus.line_count !== 3'd7 || bus.level !== 5'd9) begin miscompares++; $display("FAIL lc_sat got lc=%0d lvl=%0d want 7/9", bus.line_count, bus.level); end
    step(0, 6'h00, 0, 1, 0, 0);
    vectors++; if (bus.line_count !== 3'd6 || bus.rd_data !== 6'h08 || bus.rd_eol !== 1'b1) begin miscompares++; $display("FAIL lc_dec got lc=%0d d=%h eol=%b want 6/08/1", bus.line_count, bus.rd_data, bus.rd_eol); end
    step(1, 6'h11, 1, 1, 1, 0);
    vectors++; if (bus.level !== 5'd0 || bus.line_count !== 3'd0 || bus.empty !== 1'b1 || bus.rd_valid !== 1'b0) begin miscompares++; $display("FAIL flush got lvl=%0d lc=%0d e=%b vld=%b want 0/0/1/0", bus.level, bus.line_count, bus.empty, bus.rd_valid); end
    vectors++; if (bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin miscompares++; $display("FAIL flush_err got unf=%b ovf=%b want 1/0", bus.underflow, bus.overflow); end
    step(0, 6'h00, 0, 0, 0, 1);
    vectors++; if (bus.level !== 5'd0 || bus.underflow !== 1'b0) begin miscompares++; $display("FAIL flush_post got lvl=%0d unf=%b want 0/0", bus.level, bus.underflow); end
  endtask

  task automatic test_stream();
    logic [DW:0] q[$];
    int  sent = 0, lvl = 0, lc = 0, cyc = 0;
    bit  up = 1'b1, saw_af = 1'b0, saw_ae_drop = 1'b0;
    while ((sent < 3*DP || lvl > 0) && cyc < 600) begin
      logic do_push, do_pop, eol;
      logic [DW-1:0] d;
      logic [DW:0] x;
      if (lvl >= 14) up = 1'b0;
      else if (lvl <= 2 && sent < 3*DP) up = 1'b1;
      do_push = (sent < 3*DP) && (up || (cyc % 4 == 0));
      do_pop  = (lvl > 0) && (!up || (cyc % 3 == 0));
      d   = 6'((sent * 7 + 3) % 64);
      eol = (sent % 5 == 4);
      step(do_push, d, eol, do_pop, 0, 0);
      if (do_pop) begin
        x = q.pop_front();
        lvl--;
        if (x[DW]) lc--;
        vectors++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== x[DW-1:0] || bus.rd_eol !== x[DW]) begin miscompares++; $display("FAIL stream_rd c%0d got %b/%h/%b want 1/%h/%b", cyc, bus.rd_valid, bus.rd_data, bus.rd_eol, x[DW-1:0], x[DW]); end
      end
      if (do_push) begin
        q.push_back({eol, d});
        sent++;
        lvl++;
        if (eol) lc++;
      end
      vectors++; if (bus.level !== 5'(lvl) || bus.line_count !== 3'(lc)) begin miscompares++; $display("FAIL stream_lvl c%0d got lvl=%0d lc=%0d want %0d/%0d", cyc, bus.level, bus.line_count, lvl, lc); end
      vectors++; if (bus.almost_full !== (lvl >= DP-4) || bus.almost_empty !== (lvl <= 4)) begin miscompares++; $display("FAIL stream_th c%0d got af=%b ae=%b lvl=%0d", cyc, bus.almost_full, bus.almost_empty, lvl); end
      if (bus.almost_full) saw_af = 1'b1;
      if (!bus.almost_empty) saw_ae_drop = 1'b1;
      cyc++;
    end
    vectors++; if (sent != 3*DP || q.size() != 0) begin miscompares++; $display("FAIL stream_done got sent=%0d left=%0d want %0d/0", sent, q.size(), 3*DP); end
    vectors++; if (!saw_af || !saw_ae_drop) begin miscompares++; $display("FAIL stream_toggle got af_seen=%b ae_low_seen=%b want 1/1", saw_af, saw_ae_drop); end
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL stream_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < DP/2; i++) step(1, 6'(i + 32), i[0], 0, 0, 0);
    step(0, 6'h00, 0, 0, 1, 0);
    vectors++; if (bus.empty !== 1'b1 || bus.level !== 5'd0 || bus.line_count !== 3'd0) begin miscompares++; $display("FAIL mid_flush got e=%b lvl=%0d lc=%0d want 1/0/0", bus.empty, bus.level, bus.line_count); end
    for (int i = 0; i < DP/2; i++) step(1, 6'(i + 40), i[0], 0, 0, 0);
    vectors++; if (bus.level !== 5'd8 || bus.line_count !== 3'd4) begin miscompares++; $display("FAIL mid_refill got lvl=%0d lc=%0d want 8/4", bus.level, bus.line_count); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (bus.empty !== 1'b1 || bus.level !== 5'd0 || bus.line_count !== 3'd0 || bus.rd_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset got e=%b lvl=%0d lc=%0d vld=%b want 1/0/0/0", bus.empty, bus.level, bus.line_count, bus.rd_valid); end
    @(posedge clk); #1;
    reset = 1'b1;
    step(1, 6'h15, 0, 0, 0, 0);
    step(0, 6'h00, 0, 1, 0, 0);
    vectors++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 6'h15 || bus.level !== 5'd0) begin miscompares++; $display("FAIL mid_post got %b/%h lvl=%0d want 1/15/0", bus.rd_valid, bus.rd_data, bus.level); end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.wr_eol = 1'b0;
    bus.rd_en = 1'b0; bus.flush = 1'b0; bus.clear_err = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_empty_pushpop();
    test_line_flush();
    test_stream();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/nes_pixel_fifo.md
NES_PIXEL_FIFO -- requirements
Module: nes_pixel_fifo

Interface
REQ-001 Parameter DATA_W, default 6, colour-code width in bits.
REQ-002 Parameter DEPTH, default 512, entry count; power of two, 4..4096; AW = log2(DEPTH).
REQ-003 Parameter AFULL_TH, default DEPTH-4, almost_full asserts when level >= AFULL_TH.
REQ-004 Parameter AEMPTY_TH, default 4, almost_empty asserts when level <= AEMPTY_TH.
REQ-005 Parameter LINE_W, default 8, width of line_count.
REQ-006 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 Port reset, input, 1, asynchronous active-low reset.
REQ-008 Port wr_en, input, 1, push request.
REQ-009 Port wr_data, input, DATA_W, colour code to push.
REQ-010 Port wr_eol, input, 1, pushed entry is last pixel of a scanline.
REQ-011 Port rd_en, input, 1, pop request.
REQ-012 Port flush, input, 1, synchronous empty of the FIFO.
REQ-013 Port clear_err, input, 1, clears sticky error flags.
REQ-014 Port rd_data, output, DATA_W, popped colour code.
REQ-015 Port rd_eol, output, 1, eol tag of popped entry.
REQ-016 Port rd_valid, output, 1, rd_data/rd_eol valid this cycle.
REQ-017 Port full / empty, output, 1 each, occupancy flags.
REQ-018 Port almost_full / almost_empty, output, 1 each, threshold flags.
REQ-019 Port level, output, AW+1, current entry count 0..DEPTH.
REQ-020 Port line_count, output, LINE_W, complete scanlines (eol-tagged entries) stored.
REQ-021 Port overflow / underflow, output, 1 each, sticky error flags.

Function
REQ-022 Storage: DEPTH x (DATA_W+1) array holding {wr_eol, wr_data}.
REQ-023 Pointers wr_ptr, rd_ptr AW+1 bits, wrap modulo 2*DEPTH; full = MSBs differ and low AW bits equal; empty = pointers equal.
REQ-024 Push accepted when wr_en && (!full || rd accepted same cycle); accepted push writes at wr_ptr, wr_ptr += 1.
REQ-025 Pop accepted when rd_en && !empty; no fall-through: push to empty FIFO not readable until next cycle.
REQ-026 Read latency 1: accepted pop in cycle N -> rd_data/rd_eol registered, rd_valid=1 in cycle N+1; rd_valid=0 cycle after no accepted pop; rd_data holds last value otherwise.
REQ-027 level +1 on push only, -1 on pop only, unchanged on both or neither; flags from next-state level registered, consistent with level same cycle.
REQ-028 line_count +1 on accepted push with wr_eol, -1 on accepted pop of eol entry, unchanged when both; saturates at 2^LINE_W-1 without wrap.
REQ-029 overflow set on wr_en && full && no accepted pop; underflow set on rd_en && empty; rejected operations change no pointer or storage.
REQ-030 Sticky flags cleared by clear_err; set wins over clear in same cycle.
REQ-031 flush: next cycle pointers equal, level=0, line_count=0, empty=1, rd_valid=0; wr_en/rd_en ignored that cycle; error flags unaffected.
REQ-032 Full wrap: pointer passing DEPTH-1 returns to address 0 with MSB toggled; data order preserved across wrap.

Reset
REQ-033 reset low asynchronously forces: pointers 0, level 0, line_count 0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0, rd_eol=0, overflow=0, underflow=0.
REQ-034 Storage array not reset; contents undefined and unobservable until written.
REQ-035 Reset asserted mid-operation discards all entries; first push after release lands at address 0.

Verification
REQ-036 Push 0x27,0x0F,0x30 (eol on 0x30), then pop x3 -> rd_data 0x27,0x0F,0x30 on cycles N+1..N+3, rd_eol only on third, line_count 1 -> 0.
REQ-037 Fill to DEPTH -> full=1, level=DEPTH; extra push -> overflow=1, level unchanged; clear_err -> overflow=0.
REQ-038 Full FIFO, push+pop same cycle -> both accepted, level stays DEPTH, no overflow.
REQ-039 Empty FIFO, push+pop same cycle -> push accepted, underflow=1, rd_valid=0, level=1.
REQ-040 Stream 3*DEPTH entries with interleaved pops keeping level 1..DEPTH-1 -> output order matches input across wrap, thresholds toggle at AFULL_TH/AEMPTY_TH.
REQ-041 Half-full FIFO, flush then reset pulse mid-stream -> empty=1, level=0, line_count=0 next cycle / immediately on reset.
